// File: rtl/mem_req_pkg.sv
// Shared types and constants for the word-only memory requester.
package mem_req_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // Access size comes from funct3[1:0]; unlisted encodings behave as words.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = lo[0];
      default:     mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_requester_ld_st_align.sv
// Lane handling between 32-bit memory words and sub-word loads/stores.
module ld_st_align
  import mem_req_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b  = mem_word[{addr_lo, 3'b000} +: 8];
    lane_h  = mem_word[{addr_lo[1], 4'b0000} +: 16];
    ld_data = mem_word;
    st_word = st_data;
    case (funct3)
      F3_B: begin
        ld_data = {{24{lane_b[7]}}, lane_b};
        st_word = mem_word;
        st_word[{addr_lo, 3'b000} +: 8] = st_data[7:0];
      end
      F3_BU: begin
        ld_data = {24'h0, lane_b};
        st_word = mem_word;
        st_word[{addr_lo, 3'b000} +: 8] = st_data[7:0];
      end
      F3_H: begin
        ld_data = {{16{lane_h[15]}}, lane_h};
        st_word = mem_word;
        st_word[{addr_lo[1], 4'b0000} +: 16] = st_data[15:0];
      end
      F3_HU: begin
        ld_data = {16'h0, lane_h};
        st_word = mem_word;
        st_word[{addr_lo[1], 4'b0000} +: 16] = st_data[15:0];
      end
      default: begin
        ld_data = mem_word;
        st_word = st_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_requester.sv
// Single-outstanding load/store requester: byte/half/word accesses mapped onto
// word transactions, with read-modify-write for SB/SH and a completion timeout.
//
// state      | meaning
// S_IDLE     | ready for a core request
// S_RD_ISSUE | read pulse to memory
// S_RD_WAIT  | waiting for read completion (load data or RMW merge)
// S_WR_ISSUE | write pulse to memory
// S_WR_WAIT  | waiting for write completion
// S_RESP     | one-cycle response to the core
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int ADDR_W         = 27
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic              Request_valid,
  output logic              RE,
  output logic              WE,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [31:0]       write_data,
  input  logic              Request_completed,
  input  logic [31:0]       read_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_t state, state_nx;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       wr_word_q;
  logic [31:0]       rdata_q;
  logic [1:0]        err_q;
  logic [CNT_W-1:0]  tcnt;
  logic [CNT_W-1:0]  tcnt_inc;
  logic              tmo;
  logic              req_mis;
  logic              in_wait;
  logic [31:0]       ld_data;
  logic [31:0]       st_word;

  ld_st_align u_align (
    .funct3   (f3_q),
    .addr_lo  (addr_q[1:0]),
    .mem_word (read_data),
    .st_data  (wdata_q),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  assign req_mis  = is_misaligned(req_funct3, req_addr[1:0]);
  assign in_wait  = (state == S_RD_WAIT) || (state == S_WR_WAIT);
  // Count of wait cycles including the current one; saturates at the limit.
  assign tcnt_inc = (tcnt == TMO_CNT) ? tcnt : tcnt + 1'b1;
  assign tmo      = (tcnt_inc == TMO_CNT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    Request_valid = 1'b0;
    RE            = 1'b0;
    WE            = 1'b0;
    resp_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_mis)                        state_nx = S_RESP;
          else if (req_we && req_funct3[1])   state_nx = S_WR_ISSUE;
          else                                state_nx = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        Request_valid = 1'b1;
        RE            = 1'b1;
        state_nx      = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (Request_completed) state_nx = we_q ? S_WR_ISSUE : S_RESP;
        else if (tmo)          state_nx = S_RESP;
      end
      S_WR_ISSUE: begin
        Request_valid = 1'b1;
        WE            = 1'b1;
        state_nx      = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (Request_completed || tmo) state_nx = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
      err_q     <= ERR_OK;
      tcnt      <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        we_q      <= req_we;
        f3_q      <= req_funct3;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        wr_word_q <= req_wdata;
        rdata_q   <= '0;
        err_q     <= req_mis ? ERR_MISALIGN : ERR_OK;
      end
      if (state == S_RD_ISSUE || state == S_WR_ISSUE) tcnt <= '0;
      else if (in_wait)                               tcnt <= tcnt_inc;
      if (state == S_RD_WAIT && Request_completed) begin
        if (we_q) wr_word_q <= st_word;
        else      rdata_q   <= ld_data;
      end
      if (in_wait && !Request_completed && tmo) err_q <= ERR_TIMEOUT;
    end
  end

  assign read_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign write_addr = read_addr;
  assign write_data = wr_word_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a small word-memory responder model.
module tb_mem_requester;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [26:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        Request_valid;
  logic        RE;
  logic        WE;
  logic [26:0] read_addr;
  logic [26:0] write_addr;
  logic [31:0] write_data;
  logic        Request_completed = 1'b0;
  logic [31:0] read_data = '0;

  always #5 CLK = ~CLK;

  mem_requester dut (
    .CLK               (CLK),
    .RST               (RST),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_funct3        (req_funct3),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_err          (resp_err),
    .Request_valid     (Request_valid),
    .RE                (RE),
    .WE                (WE),
    .read_addr         (read_addr),
    .write_addr        (write_addr),
    .write_data        (write_data),
    .Request_completed (Request_completed),
    .read_data         (read_data)
  );

  int checks = 0;
  int failures = 0;

  // Memory model state
  logic [31:0] mem [16];
  logic        mem_en = 1'b1;
  int          resp_delay = 0;
  int          pend = 0;
  logic        prev_rv = 1'b0;
  logic        rv_bad = 1'b0;
  logic        addr_bad = 1'b0;
  logic [26:0] iss_addr = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        stray = 1'b0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [26:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_word;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory side, evaluated mid-cycle at the falling edge.
  task automatic mem_step();
    Request_completed = 1'b0;
    if (RST) begin
      pend    = 0;
      prev_rv = 1'b0;
      return;
    end
    if (stray) begin
      Request_completed = 1'b1;
      stray = 1'b0;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        Request_completed = 1'b1;
        read_data = mem[read_addr[5:2]];
        if (read_addr !== iss_addr) addr_bad = 1'b1;
      end
    end
    if (Request_valid) begin
      if (prev_rv) rv_bad = 1'b1;
      iss_addr = read_addr;
      if (RE) rd_cnt++;
      if (WE) begin
        wr_cnt++;
        mem[write_addr[5:2]] = write_data;
      end
      if (mem_en) pend = resp_delay + 1;
    end
    prev_rv = Request_valid;
  endtask

  task automatic tick();
    @(negedge CLK);
    mem_step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request; returns cycles from acceptance to resp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [26:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rdata, output logic [1:0] err);
    rd_cnt = 0;
    wr_cnt = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 60) begin
      tick();
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    tick();
  endtask

  initial begin
    int lat;
    int acc;
    int rsp;
    logic [31:0] rdata;
    logic [1:0]  err;

    vecs[0]  = '{1'b0, 3'b010, 27'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 3, 1, 0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 27'h13, 32'h0,        32'h80FF0000, 32'hFFFFFF80, 2'b00, 3, 1, 0, 32'h80FF0000};
    vecs[2]  = '{1'b0, 3'b100, 27'h13, 32'h0,        32'h80FF0000, 32'h00000080, 2'b00, 3, 1, 0, 32'h80FF0000};
    vecs[3]  = '{1'b0, 3'b001, 27'h12, 32'h0,        32'h80FF0000, 32'hFFFF80FF, 2'b00, 3, 1, 0, 32'h80FF0000};
    vecs[4]  = '{1'b0, 3'b101, 27'h12, 32'h0,        32'h80FF0000, 32'h000080FF, 2'b00, 3, 1, 0, 32'h80FF0000};
    vecs[5]  = '{1'b0, 3'b000, 27'h12, 32'h0,        32'h80FF0000, 32'hFFFFFFFF, 2'b00, 3, 1, 0, 32'h80FF0000};
    vecs[6]  = '{1'b1, 3'b000, 27'h21, 32'h000000AB, 32'h11223344, 32'h00000000, 2'b00, 5, 1, 1, 32'h1122AB44};
    vecs[7]  = '{1'b1, 3'b001, 27'h22, 32'hFFFFBEEF, 32'h11223344, 32'h00000000, 2'b00, 5, 1, 1, 32'hBEEF3344};
    vecs[8]  = '{1'b1, 3'b010, 27'h24, 32'hCAFEF00D, 32'h00000000, 32'h00000000, 2'b00, 3, 0, 1, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 3'b010, 27'h06, 32'h0,        32'h55555555, 32'h00000000, 2'b01, 1, 0, 0, 32'h55555555};
    vecs[10] = '{1'b1, 3'b001, 27'h05, 32'h00001234, 32'h55555555, 32'h00000000, 2'b01, 1, 0, 0, 32'h55555555};
    vecs[11] = '{1'b0, 3'b001, 27'h13, 32'h0,        32'h80FF0000, 32'h00000000, 2'b01, 1, 0, 0, 32'h80FF0000};
    vecs[12] = '{1'b0, 3'b001, 27'h14, 32'h0,        32'h7FFF8000, 32'hFFFF8000, 2'b00, 3, 1, 0, 32'h7FFF8000};
    vecs[13] = '{1'b0, 3'b101, 27'h16, 32'h0,        32'h7FFF8000, 32'h00007FFF, 2'b00, 3, 1, 0, 32'h7FFF8000};
    vecs[14] = '{1'b1, 3'b000, 27'h20, 32'h12345699, 32'hFFFFFFFF, 32'h00000000, 2'b00, 5, 1, 1, 32'hFFFFFF99};
    vecs[15] = '{1'b1, 3'b010, 27'h2A, 32'h00000001, 32'hAAAAAAAA, 32'h00000000, 2'b01, 1, 0, 0, 32'hAAAAAAAA};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_request_valid", {31'h0, Request_valid}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {30'h0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    #2 RST = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      mem[vecs[i].addr[5:2]] = vecs[i].mem_word;
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rdata, err);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {30'h0, err}, {30'h0, vecs[i].exp_err});
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_rd_pulses", i), 32'(rd_cnt), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_wr_pulses", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d_mem_word", i), mem[vecs[i].addr[5:2]], vecs[i].exp_mem);
    end

    // Memory never answers: timeout after 15 wait cycles
    mem_en = 1'b0;
    mem[4] = 32'h12345678;
    do_req(1'b0, 3'b010, 27'h10, 32'h0, lat, rdata, err);
    check("tmo_err", {30'h0, err}, 32'h2);
    check("tmo_rdata", rdata, 32'h0);
    check("tmo_latency", 32'(lat), 32'd17);
    mem_en = 1'b1;

    // Completion exactly in the 15th wait cycle is a success
    resp_delay = 14;
    do_req(1'b0, 3'b010, 27'h10, 32'h0, lat, rdata, err);
    check("late_ok_err", {30'h0, err}, 32'h0);
    check("late_ok_rdata", rdata, 32'h12345678);
    check("late_ok_latency", 32'(lat), 32'd17);
    resp_delay = 0;

    do_req(1'b0, 3'b010, 27'h10, 32'h0, lat, rdata, err);
    check("post_tmo_rdata", rdata, 32'h12345678);
    check("post_tmo_latency", 32'(lat), 32'd3);

    // Reset while waiting for a read
    mem_en = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 27'h10;
    tick();
    req_valid = 1'b0;
    tick();
    #2 RST = 1'b1;
    #1;
    check("midrst_request_valid", {31'h0, Request_valid}, 32'h0);
    check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    tick();
    #2 RST = 1'b0;
    mem_en = 1'b1;
    rd_cnt = 0;
    stray  = 1'b1;
    rsp = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_valid) rsp++;
    end
    check("stray_resp_count", 32'(rsp), 32'd0);
    check("stray_rd_pulses", 32'(rd_cnt), 32'd0);
    check("stray_req_ready", {31'h0, req_ready}, 32'h1);

    // req_valid held high: one acceptance per 4-cycle LW transaction
    mem[4] = 32'hA5A5A5A5;
    rd_cnt = 0;
    acc = 0;
    rsp = 0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 27'h10;
    for (int i = 0; i < 12; i++) begin
      if (req_valid && req_ready) acc++;
      if (resp_valid) begin
        rsp++;
        check("b2b_rdata", resp_rdata, 32'hA5A5A5A5);
      end
      tick();
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd3);
    check("b2b_responses", 32'(rsp), 32'd3);
    check("b2b_rd_pulses", 32'(rd_cnt), 32'd3);
    tick();
    tick();

    check("no_back_to_back_request_valid", {31'h0, rv_bad}, 32'h0);
    check("addr_stable_to_completion", {31'h0, addr_bad}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
